// File: rtl/mem_access_ctrl.sv
// mem_access_ctrl: load/store sequencer with sub-word merge, misalignment trap and access counters
module mem_access_ctrl #(
  parameter int CNT_W = 16
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             req_valid,
  input  logic             req_write,
  input  logic [1:0]       req_size,
  input  logic             req_unsigned,
  input  logic [31:0]      req_addr,
  input  logic [31:0]      req_wdata,
  output logic             req_ready,
  output logic             resp_valid,
  output logic [31:0]      resp_rdata,
  output logic             misalign,
  output logic             mem_read,
  output logic             mem_write,
  output logic [31:0]      mem_addr,
  output logic [31:0]      mem_wdata,
  input  logic [31:0]      mem_rdata,
  output logic [CNT_W-1:0] ld_count,
  output logic [CNT_W-1:0] st_count
);
  typedef enum logic [2:0] {IDLE, READ, WRITE, RESP, ERR} state_t;
  state_t state_q, state_d;
  logic write_q, uns_q;
  logic [1:0] size_q;
  logic [31:0] addr_q, wdata_q, rdata_q, load_v;
  logic [CNT_W-1:0] ld_q, st_q;
  logic accept, mis_req;
  logic [7:0] byte_v;
  logic [15:0] half_v;
  assign accept  = req_valid && state_q == IDLE;
  assign mis_req = req_size[1] ? req_addr[1:0] != 2'b00 : req_size[0] & req_addr[0];
  // state register; reset aborts any access in flight
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state_q <= IDLE;
    else        state_q <= state_d;
  end
  // next state and strobes, all decoded from the registered state
  always_comb begin
    state_d    = state_q;
    req_ready  = 1'b0;
    mem_read   = 1'b0;
    mem_write  = 1'b0;
    resp_valid = 1'b0;
    misalign   = 1'b0;
    unique case (state_q)
      IDLE: begin
        req_ready = 1'b1;
        if (req_valid) state_d = mis_req ? ERR : (req_write && req_size[1]) ? WRITE : READ;
      end
      READ: begin
        mem_read = 1'b1;
        state_d  = write_q ? WRITE : RESP;
      end
      WRITE: begin
        mem_write = 1'b1;
        state_d   = RESP;
      end
      RESP: begin
        resp_valid = 1'b1;
        state_d    = IDLE;
      end
      ERR: begin
        resp_valid = 1'b1;
        misalign   = 1'b1;
        state_d    = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end
  // request capture, read-data capture and saturating completion counters
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      write_q <= 1'b0;
      uns_q   <= 1'b0;
      size_q  <= 2'b00;
      addr_q  <= '0;
      wdata_q <= '0;
      rdata_q <= '0;
      ld_q    <= '0;
      st_q    <= '0;
    end else begin
      if (accept) begin
        write_q <= req_write;
        uns_q   <= req_unsigned;
        size_q  <= req_size;
        addr_q  <= req_addr;
        wdata_q <= req_wdata;
      end
      if (state_q == READ) rdata_q <= mem_rdata;
      if (state_q == RESP && !write_q && ld_q != '1) ld_q <= ld_q + 1'b1;
      if (state_q == RESP && write_q && st_q != '1) st_q <= st_q + 1'b1;
    end
  end
  assign byte_v     = rdata_q[{addr_q[1:0], 3'b000} +: 8];
  assign half_v     = rdata_q[{addr_q[1], 4'b0000} +: 16];
  assign load_v     = size_q[1] ? rdata_q :
                      size_q[0] ? {{16{~uns_q & half_v[15]}}, half_v} :
                                  {{24{~uns_q & byte_v[7]}}, byte_v};
  assign resp_rdata = (state_q == RESP && !write_q) ? load_v : 32'h0;
  assign mem_addr   = {2'b00, addr_q[31:2]};
  assign ld_count   = ld_q;
  assign st_count   = st_q;
  // store word: full word as given, or captured word with one lane replaced
  always_comb begin
    mem_wdata = rdata_q;
    if (size_q[1]) mem_wdata = wdata_q;
    else if (size_q[0]) mem_wdata[{addr_q[1], 4'b0000} +: 16] = wdata_q[15:0];
    else mem_wdata[{addr_q[1:0], 3'b000} +: 8] = wdata_q[7:0];
  end
endmodule

// File: tb/tb_mem_access_ctrl.sv
// tb_mem_access_ctrl: directed and random load/store checks against a byte-addressed memory model
module tb_mem_access_ctrl;
  localparam int CW = 2;
  logic clk = 1'b0, rst_n = 1'b0;
  logic req_valid = 1'b0, req_write = 1'b0, req_unsigned = 1'b0;
  logic [1:0] req_size = 2'b00;
  logic [31:0] req_addr = '0, req_wdata = '0;
  logic req_ready, resp_valid, misalign, mem_read, mem_write;
  logic [31:0] resp_rdata, mem_addr, mem_wdata, mem_rdata;
  logic [CW-1:0] ld_count, st_count;
  logic [31:0] mem [64];
  logic pl_en = 1'b0;
  logic [5:0] pl_idx = '0;
  logic [31:0] pl_data = '0;
  logic [7:0] rb [256];
  int total = 0, bad = 0, ldc = 0, stc = 0;

  mem_access_ctrl #(.CNT_W(CW)) dut (
    .clk(clk), .rst_n(rst_n), .req_valid(req_valid), .req_write(req_write),
    .req_size(req_size), .req_unsigned(req_unsigned), .req_addr(req_addr),
    .req_wdata(req_wdata), .req_ready(req_ready), .resp_valid(resp_valid),
    .resp_rdata(resp_rdata), .misalign(misalign), .mem_read(mem_read),
    .mem_write(mem_write), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
    .mem_rdata(mem_rdata), .ld_count(ld_count), .st_count(st_count)
  );

  always #5 clk = ~clk;
  assign mem_rdata = mem[mem_addr[5:0]];
  always @(posedge clk) begin
    if (mem_write) mem[mem_addr[5:0]] <= mem_wdata;
    else if (pl_en) mem[pl_idx] <= pl_data;
  end

  initial begin
    #500000;
    $display("FAIL watchdog timeout");
    $fatal(1, "watchdog");
  end

  task automatic chk(input string t, input logic [31:0] g, input logic [31:0] e);
    total++;
    assert (g === e) else begin
      bad++;
      $error("FAIL %s got=%h exp=%h", t, g, e);
    end
  endtask

  function automatic logic [31:0] ref_load(input logic [31:0] a, input int n, input logic u);
    logic [31:0] v = '0;
    for (int i = 0; i < n; i++) v |= 32'(rb[int'(a[7:0]) + i]) << (8 * i);
    if (!u && n < 4 && v[8 * n - 1]) v |= 32'hFFFF_FFFF << (8 * n);
    return v;
  endfunction

  function automatic logic [31:0] ref_word(input logic [31:0] a);
    int b = int'(a[7:0]) & ~3;
    return {rb[b + 3], rb[b + 2], rb[b + 1], rb[b]};
  endfunction

  // called at a falling edge; returns at the next falling edge
  task automatic preload(input int idx, input logic [31:0] d);
    pl_en = 1'b1;
    pl_idx = 6'(idx);
    pl_data = d;
    for (int i = 0; i < 4; i++) rb[idx * 4 + i] = d[8 * i +: 8];
    @(negedge clk);
    pl_en = 1'b0;
  endtask

  // called at a falling edge of an idle cycle; returns at the falling edge of the next idle cycle
  task automatic xact(input logic w, input logic [1:0] sz, input logic u,
                      input logic [31:0] a, input logic [31:0] wd_in);
    int n = (sz == 2'd0) ? 1 : (sz == 2'd1) ? 2 : 4;
    logic mis = (a & 32'(n - 1)) != 0;
    int lat_e = mis ? 1 : (!w || n == 4) ? 2 : 3;
    logic [31:0] rd_e = '0, ew = '0, rd = '0, wd = '0;
    int cyc = 0, nr = 0, nw = 0, lat = 0;
    logic got = 1'b0, mis_o = 1'b0, both = 1'b0, aerr = 1'b0;
    if (!mis && !w) begin
      rd_e = ref_load(a, n, u);
      ldc = (ldc == 3) ? 3 : ldc + 1;
    end
    if (!mis && w) begin
      for (int i = 0; i < n; i++) rb[int'(a[7:0]) + i] = wd_in[8 * i +: 8];
      ew = ref_word(a);
      stc = (stc == 3) ? 3 : stc + 1;
    end
    req_write = w; req_size = sz; req_unsigned = u; req_addr = a; req_wdata = wd_in;
    req_valid = 1'b1;
    chk("ready", 32'(req_ready), 32'd1);
    @(posedge clk);
    while (!got && cyc < 8) begin
      @(negedge clk);
      cyc++;
      req_addr = $urandom; req_wdata = $urandom; req_size = 2'($urandom);
      req_write = 1'($urandom); req_unsigned = 1'($urandom);
      nr += int'(mem_read);
      nw += int'(mem_write);
      if (mem_read && mem_write) both = 1'b1;
      if ((mem_read || mem_write) && mem_addr !== {2'b00, a[31:2]}) aerr = 1'b1;
      if (mem_write) wd = mem_wdata;
      if (resp_valid) begin
        got = 1'b1; lat = cyc; rd = resp_rdata; mis_o = misalign;
      end
    end
    req_valid = 1'b0;
    chk("resp_seen", 32'(got), 32'd1);
    chk("latency", 32'(lat), 32'(lat_e));
    chk("misalign", 32'(mis_o), 32'(mis));
    if (!w || mis) chk("rdata", rd, rd_e);
    chk("reads", 32'(nr), (!mis && (!w || n < 4)) ? 32'd1 : 32'd0);
    chk("writes", 32'(nw), (!mis && w) ? 32'd1 : 32'd0);
    chk("rd_wr_overlap", 32'(both), 32'd0);
    chk("mem_addr", 32'(aerr), 32'd0);
    if (!mis && w) chk("wdata", wd, ew);
    @(negedge clk);
    chk("ld_count", 32'(ld_count), 32'(ldc));
    chk("st_count", 32'(st_count), 32'(stc));
  endtask

  initial begin
    int k;
    logic [1:0] sz;
    logic [31:0] a;
    #1;
    chk("rst_ready", 32'(req_ready), 32'd1);
    chk("rst_resp_valid", 32'(resp_valid), 32'd0);
    chk("rst_misalign", 32'(misalign), 32'd0);
    chk("rst_strobes", {30'd0, mem_read, mem_write}, 32'd0);
    chk("rst_rdata", resp_rdata, 32'd0);
    chk("rst_mem_addr", mem_addr, 32'd0);
    chk("rst_mem_wdata", mem_wdata, 32'd0);
    chk("rst_counts", {28'd0, ld_count, st_count}, 32'd0);
    @(negedge clk);
    for (int i = 0; i < 64; i++) preload(i, $urandom);
    rst_n = 1'b1;
    @(negedge clk);
    xact(1'b1, 2'd2, 1'b0, 32'h10, 32'hDEADBEEF);
    chk("sw_mem", mem[4], 32'hDEADBEEF);
    preload(4, 32'h11223344);
    xact(1'b1, 2'd0, 1'b0, 32'h11, 32'h000000AA);
    chk("sb_mem", mem[4], 32'h1122AA44);
    preload(4, 32'h8000F0FF);
    xact(1'b0, 2'd0, 1'b0, 32'h10, 32'h0);
    xact(1'b0, 2'd0, 1'b1, 32'h10, 32'h0);
    xact(1'b0, 2'd1, 1'b0, 32'h12, 32'h0);
    xact(1'b0, 2'd1, 1'b1, 32'h12, 32'h0);
    xact(1'b0, 2'd2, 1'b0, 32'h13, 32'h0);
    xact(1'b1, 2'd3, 1'b0, 32'h22, 32'h12345678);
    xact(1'b1, 2'd1, 1'b0, 32'h21, 32'h0000BEEF);
    req_write = 1'b1; req_size = 2'd1; req_unsigned = 1'b0;
    req_addr = 32'h22; req_wdata = 32'h0000CAFE; req_valid = 1'b1;
    @(posedge clk);
    k = 0;
    do begin
      @(negedge clk);
      k++;
    end while (!mem_write && k < 5);
    chk("abort_write_seen", 32'(mem_write), 32'd1);
    rst_n = 1'b0;
    req_valid = 1'b0;
    #1;
    chk("abort_mem_write", 32'(mem_write), 32'd0);
    chk("abort_ready", 32'(req_ready), 32'd1);
    chk("abort_counts", {28'd0, ld_count, st_count}, 32'd0);
    ldc = 0;
    stc = 0;
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    xact(1'b0, 2'd1, 1'b1, 32'h22, 32'h0);
    xact(1'b0, 2'd2, 1'b0, 32'h20, 32'h0);
    for (int i = 0; i < 3; i++) xact(1'b0, 2'd0, 1'($urandom), 32'($urandom_range(0, 255)), 32'h0);
    for (int i = 0; i < 250; i++) begin
      sz = 2'($urandom);
      a = 32'($urandom_range(0, 255));
      if ($urandom_range(0, 3) != 0) a &= (sz == 2'd0) ? 32'hFF : (sz == 2'd1) ? 32'hFE : 32'hFC;
      xact(1'($urandom), sz, 1'($urandom), a, $urandom);
    end
    for (int i = 0; i < 64; i++) chk("final_mem", mem[i], ref_word(32'(i * 4)));
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
